// File: rtl/dmem_pkg.sv
// Shared encodings and the load-extension helper for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_SIZE     = 2'b11
    } err_e;

    // Pick the addressed byte/half out of a full word and sign- or zero-extend it.
    // Halves are only ever aligned here, so offset bit 1 alone selects the half.
    function automatic logic [31:0] ext_load(input logic [31:0] w,
                                             input logic [1:0]  off,
                                             input logic [1:0]  sz,
                                             input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channels between the load/store unit and the data memory.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: DEPTH_WORDS x 8 synchronous RAM, no reset.
module dmem_bank #(
    parameter int  DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);
    logic [7:0] mem_q [DEPTH_WORDS];
    logic [7:0] rdata_q;

    // Read-before-write port; the read register only moves when enabled so it holds under stall.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) mem_q[addr] <= wdata;
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: four byte banks, fault checks, one-entry registered response.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic   clock,
    input  logic   reset_n,
    dmem_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic             ready;
    logic             accept;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    err_e             req_err;
    logic             wr_ok;
    logic [3:0]       lane_we;
    logic [31:0]      lane_wdata;
    logic [31:0]      rd_word;

    logic       rsp_valid_q, rsp_valid_d;
    err_e       err_q,       err_d;
    logic [1:0] off_q,       off_d;
    logic [1:0] size_q,      size_d;
    logic       sgn_q,       sgn_d;
    logic       write_q,     write_d;

    // Request decode: handshake, fault classification in priority order, lane enables.
    always_comb begin
        ready  = !rsp_valid_q || bus.rsp_ready;
        accept = bus.req_valid && ready;
        off    = bus.req_addr[1:0];
        idx    = bus.req_addr[IDX_W+1:2];

        if (bus.req_size == SZ_ILL)
            req_err = ERR_SIZE;
        else if ((bus.req_size == SZ_HALF && off[0]) || (bus.req_size == SZ_WORD && off != 2'b00))
            req_err = ERR_MISALIGN;
        else if (bus.req_addr[31:IDX_W+2] != '0)
            req_err = ERR_RANGE;   // no aliasing past the end of the array
        else
            req_err = ERR_OK;

        wr_ok = accept && bus.req_write && (req_err == ERR_OK);
        case (bus.req_size)
            SZ_BYTE: begin
                lane_we    = 4'b0001 << off;
                lane_wdata = {4{bus.req_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_we    = 4'b0011 << off;
                lane_wdata = {2{bus.req_wdata[15:0]}};
            end
            SZ_WORD: begin
                lane_we    = 4'b1111;
                lane_wdata = bus.req_wdata;
            end
            default: begin
                lane_we    = 4'b0000;
                lane_wdata = bus.req_wdata;
            end
        endcase
        lane_we = lane_we & {4{wr_ok}};
    end

    // Four byte lanes; every accept reads all lanes, so loads see the previous edge's store.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
            .clock (clock),
            .en    (accept),
            .we    (lane_we[g]),
            .addr  (idx),
            .wdata (lane_wdata[8*g +: 8]),
            .rdata (rd_word[8*g +: 8])
        );
    end

    // Response-stage next state: load on accept, retire on rsp_ready, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        err_d       = err_q;
        off_d       = off_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        write_d     = write_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            err_d       = req_err;
            off_d       = off;
            size_d      = bus.req_size;
            sgn_d       = bus.req_signed;
            write_d     = bus.req_write;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response-stage registers; reset drops any in-flight response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            err_q       <= ERR_OK;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            sgn_q       <= 1'b0;
            write_q     <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            write_q     <= write_d;
        end
    end

    // Outputs: extension works on the held bank word, zeroed for stores, faults and idle.
    always_comb begin
        bus.req_ready = ready;
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = '0;
        if (rsp_valid_q && !write_q && err_q == ERR_OK)
            bus.rsp_rdata = ext_load(rd_word, off_q, size_q, sgn_q);
    end
endmodule
